// File: rtl/mux_2_1_rr_arbiter.sv
`default_nettype none
// ============================================================================
// mux_2_1_rr_arbiter : packet-locked round-robin 2:1 arbiter with one
//                      registered output stage and registered select s.
// Revision: 1.0
// ============================================================================
module mux_2_1_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    input  logic             a_last,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    input  logic             b_last,
    output logic             b_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             s
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             s_q, s_d;

    logic             load_en;
    logic             grant_a, grant_b;
    logic             acc_a, acc_b, acc;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic             sel_idx;

    assign load_en = ~valid_q | out_ready;

    always_comb begin
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        state_d  = state_q;
        ptr_d    = ptr_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        s_d      = s_q;

        case (state_q)
            IDLE: begin
                if (a_valid && b_valid) begin
                    grant_a = ~ptr_q;
                    grant_b = ptr_q;
                end else begin
                    grant_a = a_valid;
                    grant_b = b_valid;
                end
            end
            LOCK_A:  grant_a = 1'b1;
            LOCK_B:  grant_b = 1'b1;
            default: ;
        endcase

        // rst_n gating keeps both readies low while reset is held
        a_ready = rst_n & load_en & grant_a;
        b_ready = rst_n & load_en & grant_b;

        acc_a    = a_valid & a_ready;
        acc_b    = b_valid & b_ready;
        acc      = acc_a | acc_b;
        sel_idx  = acc_b;
        sel_data = acc_b ? b_data : a_data;
        sel_last = acc_b ? b_last : a_last;

        if (acc) begin
            if (sel_last) begin
                state_d = IDLE;
                ptr_d   = ~sel_idx;
            end else begin
                state_d = sel_idx ? LOCK_B : LOCK_A;
            end
        end

        if (load_en) begin
            valid_d = acc;
            if (acc) begin
                data_d = sel_data;
                last_d = sel_last;
                s_d    = sel_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            s_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            s_q     <= s_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign s         = s_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_2_1_rr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_mux_2_1_rr_arbiter : directed self-checking bench for mux_2_1_rr_arbiter.
// Revision: 1.0
// ============================================================================
module tb_mux_2_1_rr_arbiter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] a_data, b_data, out_data;
    logic             a_valid, a_last, a_ready;
    logic             b_valid, b_last, b_ready;
    logic             out_valid, out_last, out_ready, s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_2_1_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_data    (a_data),
        .a_valid   (a_valid),
        .a_last    (a_last),
        .a_ready   (a_ready),
        .b_data    (b_data),
        .b_valid   (b_valid),
        .b_last    (b_last),
        .b_ready   (b_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .s         (s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rdy(input string tag, input logic ea, input logic eb);
        chk({tag, ".a_ready"}, {31'd0, a_ready}, {31'd0, ea});
        chk({tag, ".b_ready"}, {31'd0, b_ready}, {31'd0, eb});
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [7:0] ed,
                           input logic el, input logic es);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
        chk({tag, ".out_data"},  {24'd0, out_data},  {24'd0, ed});
        chk({tag, ".out_last"},  {31'd0, out_last},  {31'd0, el});
        chk({tag, ".s"},         {31'd0, s},         {31'd0, es});
    endtask

    task automatic set_a(input logic v, input logic [7:0] d, input logic l);
        a_valid = v; a_data = d; a_last = l;
    endtask

    task automatic set_b(input logic v, input logic [7:0] d, input logic l);
        b_valid = v; b_data = d; b_last = l;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with A already presenting a beat
        rst_n = 1'b0;
        out_ready = 1'b1;
        set_a(1'b1, 8'h11, 1'b1);
        set_b(1'b0, 8'h00, 1'b0);
        tick(); tick();
        chk_rdy("reset", 1'b0, 1'b0);
        chk_out("reset", 1'b0, 8'h00, 1'b0, 1'b0);

        // Release: first edge accepts A
        rst_n = 1'b1;
        #1;
        chk_rdy("first", 1'b1, 1'b0);
        tick();
        chk_out("first", 1'b1, 8'h11, 1'b1, 1'b0);

        // Both single-beat every cycle; ptr now prefers B
        set_a(1'b1, 8'h21, 1'b1);
        set_b(1'b1, 8'h31, 1'b1);
        #1;
        chk_rdy("rr0", 1'b0, 1'b1);
        tick(); chk_out("rr0", 1'b1, 8'h31, 1'b1, 1'b1);
        chk_rdy("rr1", 1'b1, 1'b0);
        tick(); chk_out("rr1", 1'b1, 8'h21, 1'b1, 1'b0);
        tick(); chk_out("rr2", 1'b1, 8'h31, 1'b1, 1'b1);
        tick(); chk_out("rr3", 1'b1, 8'h21, 1'b1, 1'b0);

        // A 3-beat packet while B waits (ptr prefers B, so A starts alone)
        set_a(1'b1, 8'hA0, 1'b0);
        set_b(1'b0, 8'h00, 1'b0);
        tick(); chk_out("pktA0", 1'b1, 8'hA0, 1'b0, 1'b0);
        set_a(1'b1, 8'hA1, 1'b0);
        set_b(1'b1, 8'hB0, 1'b1);
        #1;
        chk_rdy("lockA1", 1'b1, 1'b0);
        tick(); chk_out("pktA1", 1'b1, 8'hA1, 1'b0, 1'b0);
        set_a(1'b1, 8'hA2, 1'b1);
        #1;
        chk_rdy("lockA2", 1'b1, 1'b0);
        tick(); chk_out("pktA2", 1'b1, 8'hA2, 1'b1, 1'b0);
        set_a(1'b0, 8'h00, 1'b0);
        #1;
        chk_rdy("afterA", 1'b0, 1'b1);
        tick(); chk_out("pktB0", 1'b1, 8'hB0, 1'b1, 1'b1);

        // Stall 4 cycles with both valid; ptr prefers A
        out_ready = 1'b0;
        set_a(1'b1, 8'hC1, 1'b1);
        set_b(1'b1, 8'hC2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_rdy("stall", 1'b0, 1'b0);
            tick();
            chk_out("stall", 1'b1, 8'hB0, 1'b1, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        chk_rdy("resume", 1'b1, 1'b0);
        tick(); chk_out("resumeA", 1'b1, 8'hC1, 1'b1, 1'b0);
        tick(); chk_out("resumeB", 1'b1, 8'hC2, 1'b1, 1'b1);
        set_a(1'b0, 8'h00, 1'b0);
        set_b(1'b0, 8'h00, 1'b0);
        tick(); chk_out("drain", 1'b0, 8'hC2, 1'b1, 1'b1);

        // LOCK_B with B gap while A waits
        set_b(1'b1, 8'hD0, 1'b0);
        tick(); chk_out("pktD0", 1'b1, 8'hD0, 1'b0, 1'b1);
        set_b(1'b0, 8'h00, 1'b0);
        set_a(1'b1, 8'hE0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk_rdy("gapB", 1'b0, 1'b1);
            tick();
            chk_out("gapB", 1'b0, 8'hD0, 1'b0, 1'b1);
        end
        set_b(1'b1, 8'hD1, 1'b0);
        #1;
        chk_rdy("pktD1", 1'b0, 1'b1);
        tick(); chk_out("pktD1", 1'b1, 8'hD1, 1'b0, 1'b1);
        set_b(1'b1, 8'hD2, 1'b1);
        tick(); chk_out("pktD2", 1'b1, 8'hD2, 1'b1, 1'b1);
        set_b(1'b0, 8'h00, 1'b0);
        tick(); chk_out("afterD", 1'b1, 8'hE0, 1'b1, 1'b0);
        set_a(1'b0, 8'h00, 1'b0);

        // Reset mid-packet while output is held
        set_b(1'b1, 8'hF0, 1'b0);
        tick(); chk_out("pktF0", 1'b1, 8'hF0, 1'b0, 1'b1);
        out_ready = 1'b0;
        set_b(1'b1, 8'hF1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("midrst", 1'b0, 8'h00, 1'b0, 1'b0);
        chk_rdy("midrst", 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        set_a(1'b1, 8'h60, 1'b1);
        #1;
        chk_rdy("postrst", 1'b1, 1'b0);
        tick(); chk_out("postrst", 1'b1, 8'h60, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
